// File: rtl/bcd_time_counter.sv
// Purpose : counts 1 s tick pulses into a 24-hour HH:MM:SS time in packed BCD,
//           with run/stop control, a range-checked time-load port and minute/day carry pulses.
// Latency : fields, load_err, min_carry and day_carry are registered; they appear one cycle after the sampling edge.
// Backpres: load_rdy is high only in STOP. A load held while running waits until the block stops.
// Ports   : sclk, rst_n (async, active low), tick_1s, run, clear,
//           load_vld/load_rdy/load_time (ready/valid load of {HH,MM,SS}), load_err,
//           hour_bcd/min_bcd/sec_bcd, min_carry, day_carry.
// Option  : BCD_TIME_COUNTER_ALARM_EN adds alarm_time[15:0] ({HH,MM}) and the alarm_hit pulse.
module bcd_time_counter #(
  parameter logic [7:0] HOUR_MAX = 8'h23
) (
  input  logic        sclk,
  input  logic        rst_n,
  input  logic        tick_1s,
  input  logic        run,
  input  logic        clear,
  input  logic        load_vld,
  output logic        load_rdy,
  input  logic [23:0] load_time,
  output logic        load_err,
  output logic [7:0]  hour_bcd,
  output logic [7:0]  min_bcd,
  output logic [7:0]  sec_bcd,
  output logic        min_carry,
  output logic        day_carry
`ifdef BCD_TIME_COUNTER_ALARM_EN
  ,
  input  logic [15:0] alarm_time,
  output logic        alarm_hit
`endif
);

  typedef enum logic {ST_STOP = 1'b0, ST_RUN = 1'b1} state_t;

  state_t r_state;

  // Two-digit BCD increment; the wrap to 00 is handled by the caller.
  function automatic logic [7:0] bcd_inc(input logic [7:0] v);
    if (v[3:0] == 4'd9) bcd_inc = {v[7:4] + 4'd1, 4'd0};
    else                bcd_inc = {v[7:4], v[3:0] + 4'd1};
  endfunction

  logic       w_tick;
  logic       w_load;
  logic       w_load_ok;
  logic       w_sec_wrap;
  logic       w_min_wrap;
  logic       w_hour_wrap;
  logic [7:0] w_sec_nx;
  logic [7:0] w_min_nx;
  logic [7:0] w_hour_nx;

  assign load_rdy = (r_state == ST_STOP);

  // A tick on the STOP->RUN edge sees r_state==STOP and is dropped.
  assign w_tick = (r_state == ST_RUN) && tick_1s;
  assign w_load = load_vld && load_rdy;

  // A plain binary compare orders valid BCD correctly, so the hour limit check
  // is safe once both hour digits are known to be <= 9.
  assign w_load_ok = (load_time[23:20] <= 4'd9) && (load_time[19:16] <= 4'd9) &&
                     (load_time[23:16] <= HOUR_MAX) &&
                     (load_time[15:12] <= 4'd5) && (load_time[11:8] <= 4'd9) &&
                     (load_time[7:4]   <= 4'd5) && (load_time[3:0]  <= 4'd9);

  assign w_sec_wrap  = (sec_bcd  == 8'h59);
  assign w_min_wrap  = (min_bcd  == 8'h59);
  assign w_hour_wrap = (hour_bcd == HOUR_MAX);

  assign w_sec_nx  = w_sec_wrap ? 8'h00 : bcd_inc(sec_bcd);
  assign w_min_nx  = !w_sec_wrap ? min_bcd :
                     (w_min_wrap ? 8'h00 : bcd_inc(min_bcd));
  assign w_hour_nx = !(w_sec_wrap && w_min_wrap) ? hour_bcd :
                     (w_hour_wrap ? 8'h00 : bcd_inc(hour_bcd));

  always_ff @(posedge sclk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= ST_STOP;
      hour_bcd  <= 8'h00;
      min_bcd   <= 8'h00;
      sec_bcd   <= 8'h00;
      load_err  <= 1'b0;
      min_carry <= 1'b0;
      day_carry <= 1'b0;
`ifdef BCD_TIME_COUNTER_ALARM_EN
      alarm_hit <= 1'b0;
`endif
    end else begin
      // Pulse outputs default low; they are only raised for a single cycle.
      load_err  <= 1'b0;
      min_carry <= 1'b0;
      day_carry <= 1'b0;
`ifdef BCD_TIME_COUNTER_ALARM_EN
      alarm_hit <= 1'b0;
`endif
      case (r_state)
        ST_STOP: if (run)  r_state <= ST_RUN;
        ST_RUN:  if (!run) r_state <= ST_STOP;
        default:           r_state <= ST_STOP;
      endcase

      // clear > load > tick; a clear or load swallows a coincident tick.
      if (clear) begin
        hour_bcd <= 8'h00;
        min_bcd  <= 8'h00;
        sec_bcd  <= 8'h00;
      end else if (w_load) begin
        if (w_load_ok) begin
          hour_bcd <= load_time[23:16];
          min_bcd  <= load_time[15:8];
          sec_bcd  <= load_time[7:0];
        end else begin
          load_err <= 1'b1;
        end
      end else if (w_tick) begin
        hour_bcd  <= w_hour_nx;
        min_bcd   <= w_min_nx;
        sec_bcd   <= w_sec_nx;
        min_carry <= w_sec_wrap;
        day_carry <= w_sec_wrap && w_min_wrap && w_hour_wrap;
`ifdef BCD_TIME_COUNTER_ALARM_EN
        alarm_hit <= ({w_hour_nx, w_min_nx, w_sec_nx} == {alarm_time, 8'h00});
`endif
      end
    end
  end

endmodule

// File: tb/tb_bcd_time_counter.sv
// Purpose : directed self-checking bench for bcd_time_counter.
// Latency : expectations are queued before each step and compared 1 ns after the edge.
// Backpres: exercises load_rdy gating while running and the accepted load after stop.
module tb_bcd_time_counter;

  logic        sclk = 1'b0;
  logic        rst_n;
  logic        tick_1s;
  logic        run;
  logic        clear;
  logic        load_vld;
  logic        load_rdy;
  logic [23:0] load_time;
  logic        load_err;
  logic [7:0]  hour_bcd;
  logic [7:0]  min_bcd;
  logic [7:0]  sec_bcd;
  logic        min_carry;
  logic        day_carry;
  logic        w_alarm;
  logic [15:0] alarm_time;

  int checks = 0;
  int errors = 0;

  logic [28:0] exp_q[$];
  string       tag_q[$];

`ifdef BCD_TIME_COUNTER_ALARM_EN
  localparam logic ALM = 1'b1;
  logic alarm_hit;
  assign w_alarm = alarm_hit;
`else
  localparam logic ALM = 1'b0;
  assign w_alarm = 1'b0;
`endif

  always #10 sclk = ~sclk;

  bcd_time_counter #(.HOUR_MAX(8'h23)) dut (
    .sclk(sclk), .rst_n(rst_n), .tick_1s(tick_1s), .run(run), .clear(clear),
    .load_vld(load_vld), .load_rdy(load_rdy), .load_time(load_time),
    .load_err(load_err), .hour_bcd(hour_bcd), .min_bcd(min_bcd),
    .sec_bcd(sec_bcd), .min_carry(min_carry), .day_carry(day_carry)
`ifdef BCD_TIME_COUNTER_ALARM_EN
    , .alarm_time(alarm_time), .alarm_hit(alarm_hit)
`endif
  );

  // Expected snapshot: {alarm, rdy, err, min_carry, day_carry, HH, MM, SS}.
  function automatic logic [28:0] mk(input logic alm, input logic rdy, input logic err,
                                     input logic mc, input logic dc, input logic [23:0] t);
    mk = {alm, rdy, err, mc, dc, t};
  endfunction

  function automatic logic [7:0] to_bcd(input int v);
    logic [3:0] hi;
    logic [3:0] lo;
    hi = 4'(v / 10);
    lo = 4'(v % 10);
    to_bcd = {hi, lo};
  endfunction

  task automatic push(input string tag, input logic [28:0] e);
    tag_q.push_back(tag);
    exp_q.push_back(e);
  endtask

  task automatic chk();
    logic [28:0] obs;
    logic [28:0] e;
    string       t;
    obs = {w_alarm, load_rdy, load_err, min_carry, day_carry, hour_bcd, min_bcd, sec_bcd};
    e = exp_q.pop_front();
    t = tag_q.pop_front();
    checks++;
    assert (obs === e) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", t, obs, e);
    end
  endtask

  task automatic step();
    @(posedge sclk);
    #1;
  endtask

  task automatic tick();
    tick_1s = 1'b1;
    step();
    tick_1s = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end

  initial begin
    rst_n = 1'b1; tick_1s = 1'b0; run = 1'b0; clear = 1'b0;
    load_vld = 1'b0; load_time = 24'h0; alarm_time = 16'h2222;

    // Asynchronous reset before any clock edge.
    #2 rst_n = 1'b0;
    #1;
    push("reset_async", mk(0, 1, 0, 0, 0, 24'h000000)); chk();
    step(); step();
    rst_n = 1'b1;
    step();
    push("reset_release_stop", mk(0, 1, 0, 0, 0, 24'h000000)); chk();

    // Start running; load_rdy drops with the registered state.
    run = 1'b1;
    push("run_rdy_low", mk(0, 0, 0, 0, 0, 24'h000000));
    step(); chk();

    // 61 ticks with an idle cycle between each; minute carry after the 60th only.
    for (int n = 1; n <= 61; n++) begin
      push($sformatf("tick%0d", n),
           mk(0, 0, 0, (n % 60) == 0, 0, {8'h00, to_bcd(n / 60), to_bcd(n % 60)}));
      tick(); chk();
      push($sformatf("idle%0d", n),
           mk(0, 0, 0, 0, 0, {8'h00, to_bcd(n / 60), to_bcd(n % 60)}));
      step(); chk();
    end

    // Day wrap from 23:59:58; the tick on the STOP->RUN edge is dropped.
    run = 1'b0; step();
    load_vld = 1'b1; load_time = 24'h235958;
    push("load_235958", mk(0, 1, 0, 0, 0, 24'h235958));
    step(); chk();
    load_vld = 1'b0;
    run = 1'b1;
    push("tick_on_start_ignored", mk(0, 0, 0, 0, 0, 24'h235958));
    tick(); chk();
    push("to_235959", mk(0, 0, 0, 0, 0, 24'h235959));
    tick(); chk();
    push("day_wrap", mk(0, 0, 0, 1, 1, 24'h000000));
    tick(); chk();
    push("day_carry_drop", mk(0, 0, 0, 0, 0, 24'h000000));
    step(); chk();

    // Range-checked loads while stopped.
    run = 1'b0; step();
    load_vld = 1'b1; load_time = 24'h236000;
    push("bad_min_tens", mk(0, 1, 1, 0, 0, 24'h000000));
    step(); chk();
    load_time = 24'h1A0000;
    push("bad_hour_digit", mk(0, 1, 1, 0, 0, 24'h000000));
    step(); chk();
    load_time = 24'h240000;
    push("bad_hour_max", mk(0, 1, 1, 0, 0, 24'h000000));
    step(); chk();
    load_time = 24'h120000;
    push("good_120000", mk(0, 1, 0, 0, 0, 24'h120000));
    step(); chk();
    load_vld = 1'b0;

    // Load held while running waits for stop, then lands two cycles after run drops.
    run = 1'b1;
    step();
    load_vld = 1'b1; load_time = 24'h010203;
    push("load_blocked_run", mk(0, 0, 0, 0, 0, 24'h120000));
    step(); chk();
    run = 1'b0;
    push("load_blocked_stopping", mk(0, 1, 0, 0, 0, 24'h120000));
    step(); chk();
    push("load_after_stop", mk(0, 1, 0, 0, 0, 24'h010203));
    step(); chk();

    // Load coincident with STOP->RUN is accepted.
    load_time = 24'h000058; run = 1'b1;
    push("load_on_start", mk(0, 0, 0, 0, 0, 24'h000058));
    step(); chk();
    load_vld = 1'b0;

    // Alarm at 00:01 fires on the tick that reaches 00:01:00.
    alarm_time = 16'h0001;
    push("alarm_pre", mk(0, 0, 0, 0, 0, 24'h000059));
    tick(); chk();
    push("alarm_hit", mk(ALM, 0, 0, 1, 0, 24'h000100));
    tick(); chk();
    push("alarm_drop", mk(0, 0, 0, 0, 0, 24'h000100));
    step(); chk();

    // Clear coincident with a tick at 00:00:59: no carry, stays running.
    run = 1'b0; step();
    load_vld = 1'b1; load_time = 24'h000059; step();
    load_vld = 1'b0; run = 1'b1; step();
    clear = 1'b1;
    push("clear_beats_tick", mk(0, 0, 0, 0, 0, 24'h000000));
    tick(); chk();
    clear = 1'b0;
    push("run_after_clear", mk(0, 0, 0, 0, 0, 24'h000001));
    tick(); chk();
    push("run_after_clear2", mk(0, 0, 0, 0, 0, 24'h000002));
    tick(); chk();

    // Reset mid-cycle clears outputs without a clock edge.
    #4 rst_n = 1'b0;
    #1;
    push("reset_mid", mk(0, 1, 0, 0, 0, 24'h000000)); chk();
    step();
    #3 rst_n = 1'b1;
    #1;
    push("reset_rel_stop", mk(0, 1, 0, 0, 0, 24'h000000)); chk();
    step();
    push("rerun_after_reset", mk(0, 0, 0, 0, 0, 24'h000000)); chk();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
